// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
//   imem_loader_state_t : loader FSM states
//   HdrBytes            : bytes in the little-endian word-count header
//   MaxCountWidth       : width of the header word count
//   idx_width()         : byte-index width for a given bytes-per-word (min 1)
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_LO = 3'd1,
        HDR_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } imem_loader_state_t;

    localparam int HdrBytes      = 2;
    localparam int MaxCountWidth = 16;

    // A single-byte word still needs a 1-bit index register.
    function automatic int idx_width(input int bytes_per_word);
        return (bytes_per_word > 1) ? $clog2(bytes_per_word) : 1;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into little-endian Width-bit words.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart packing at byte 0 (priority over byte_en)
//   byte_in    : incoming byte
//   byte_en    : byte_in is consumed this cycle
//   word       : assembly register with the in-flight byte already merged,
//                so the completed word is available in the cycle its last
//                byte arrives
//   last       : the next consumed byte completes a word
module byte_packer
    import imem_loader_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [7:0]       byte_in,
    input  logic             byte_en,
    output logic [Width-1:0] word,
    output logic             last
);

    localparam int BytesPerWord = Width / 8;
    localparam int IdxWidth     = idx_width(BytesPerWord);

    logic [IdxWidth-1:0] idx_r;
    logic [Width-1:0]    asm_r;

    assign last = (idx_r == IdxWidth'(BytesPerWord - 1));

    // Byte index and assembly register; the index wraps after the last byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r <= '0;
            asm_r <= '0;
        end else if (clear) begin
            idx_r <= '0;
        end else if (byte_en) begin
            for (int k = 0; k < BytesPerWord; k++) begin
                if (idx_r == IdxWidth'(k)) begin
                    asm_r[8*k +: 8] <= byte_in;
                end
            end
            idx_r <= last ? '0 : idx_r + IdxWidth'(1);
        end
    end

    // Merge the in-flight byte into its lane of the outgoing word.
    always_comb begin
        word = asm_r;
        for (int k = 0; k < BytesPerWord; k++) begin
            if (byte_en && (idx_r == IdxWidth'(k))) begin
                word[8*k +: 8] = byte_in;
            end else begin
                word[8*k +: 8] = asm_r[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Reads a 16-bit little-endian word count, then packs following bytes into
// Width-bit words and writes them to incrementing addresses. The core is held
// in reset (cpu_hold) until the whole image has been written.
//   clk, reset         : clock, synchronous active-high reset
//   start              : begin a load (honoured in IDLE, DONE, ERROR)
//   in_data/valid/ready: byte stream handshake
//   mem_we/addr/wdata  : instruction memory write port (registered)
//   cpu_hold           : high except after a successful load
//   done, error        : level status of the last load
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter  int Width        = 32,
    parameter  int Depth        = 32,
    localparam int AddrWidth    = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int BytesPerWord = Width / 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 mem_we,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [Width-1:0]     mem_wdata,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 error
);

    localparam logic [MaxCountWidth-1:0] DepthCount = MaxCountWidth'(Depth);

    imem_loader_state_t       state_r;
    imem_loader_state_t       next_state;
    logic [MaxCountWidth-1:0] count_r;
    logic [MaxCountWidth-1:0] hdr_count;
    logic [AddrWidth-1:0]     word_idx_r;
    logic                     xfer;
    logic                     last_word;
    logic                     pk_clear;
    logic                     pk_en;
    logic [Width-1:0]         pk_word;
    logic                     pk_last;

    assign xfer      = in_valid && in_ready;
    assign hdr_count = {in_data, count_r[7:0]};
    assign last_word = (MaxCountWidth'(word_idx_r) == (count_r - MaxCountWidth'(1)));

    byte_packer #(
        .Width (Width)
    ) u_packer (
        .clk     (clk),
        .reset   (reset),
        .clear   (pk_clear),
        .byte_in (in_data),
        .byte_en (pk_en),
        .word    (pk_word),
        .last    (pk_last)
    );

    // Next-state decode and packer control.
    always_comb begin
        next_state = state_r;
        pk_clear   = 1'b0;
        pk_en      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) next_state = HDR_LO;
                else       next_state = IDLE;
            end
            HDR_LO: begin
                if (xfer) next_state = HDR_HI;
                else      next_state = HDR_LO;
            end
            HDR_HI: begin
                if (!xfer) begin
                    next_state = HDR_HI;
                end else if (hdr_count == MaxCountWidth'(0)) begin
                    next_state = DONE;
                end else if (hdr_count > DepthCount) begin
                    next_state = ERROR;
                end else begin
                    next_state = DATA;
                    pk_clear   = 1'b1;
                end
            end
            DATA: begin
                pk_en = xfer;
                if (xfer && pk_last) next_state = WRITE;
                else                 next_state = DATA;
            end
            WRITE: begin
                pk_clear = 1'b1;
                if (last_word) next_state = DONE;
                else           next_state = DATA;
            end
            DONE, ERROR: begin
                if (start) next_state = HDR_LO;
                else       next_state = state_r;
            end
            default: next_state = IDLE;
        endcase
    end

    // State, header count, word index and registered outputs.
    // Outputs are decoded from next_state so they line up with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            count_r    <= '0;
            word_idx_r <= '0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_r  <= next_state;
            in_ready <= (next_state inside {HDR_LO, HDR_HI, DATA});
            mem_we   <= (next_state == WRITE);
            done     <= (next_state == DONE);
            error    <= (next_state == ERROR);
            cpu_hold <= (next_state != DONE);

            if ((state_r == HDR_LO) && xfer) begin
                count_r[7:0] <= in_data;
            end else if ((state_r == HDR_HI) && xfer) begin
                count_r[15:8] <= in_data;
            end

            if ((state_r == HDR_HI) && (next_state == DATA)) begin
                word_idx_r <= '0;
            end else if ((state_r == WRITE) && (next_state == DATA)) begin
                word_idx_r <= word_idx_r + AddrWidth'(1);
            end

            // Capture the completed word on the edge that accepts its last byte.
            if ((state_r == DATA) && (next_state == WRITE)) begin
                mem_addr  <= word_idx_r;
                mem_wdata <= pk_word;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (Width=32, Depth=32).
module tb_imem_loader;

    localparam int W     = 32;
    localparam int D     = 32;
    localparam int AW    = 5;
    localparam int BPW   = W / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int busy_writes = 0;

    logic [7:0]    img_q[$];
    logic [AW-1:0] wa_q[$];
    logic [W-1:0]  wd_q[$];

    imem_loader #(.Width(W), .Depth(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write, and flag any write cycle that also accepts bytes.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            if (in_ready !== 1'b0) busy_writes <= busy_writes + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic clear_capture();
        wa_q.delete();
        wd_q.delete();
    endtask

    // Offer one byte and hold it until the handshake completes.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int  t;
        bit  ok;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        forever begin
            ok = (in_ready === 1'b1);
            @(posedge clk); #1;
            if (ok) break;
            t++;
            if (t > 50) begin
                chk("handshake_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic send_range(input int from, input int upto, input bit gaps);
        for (int i = from; i <= upto; i++) send_byte(img_q[i], gaps);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((done !== 1'b1) && (t < 10)) begin
            @(posedge clk); #1;
            t++;
        end
    endtask

    // Random image: count words of random data behind a little-endian header.
    task automatic build_image(input int count);
        img_q.delete();
        img_q.push_back(count[7:0]);
        img_q.push_back(count[15:8]);
        for (int i = 0; i < count * BPW; i++) img_q.push_back(8'($urandom));
    endtask

    // Reference: word w is bytes 2+4w .. 2+4w+3 of the image, LSB first.
    task automatic check_writes(input string tag);
        int           cnt;
        logic [63:0]  exp;
        cnt = int'(img_q[0]) + 256 * int'(img_q[1]);
        chk({tag, "_wr_count"}, 64'(wa_q.size()), 64'(cnt));
        for (int w = 0; (w < cnt) && (w < wa_q.size()); w++) begin
            exp = 64'd0;
            for (int k = 0; k < BPW; k++) exp = exp | (64'(img_q[2 + w*BPW + k]) << (8*k));
            chk({tag, "_wr_addr"}, 64'(wa_q[w]), 64'(w));
            chk({tag, "_wr_data"}, 64'(wd_q[w]), exp);
        end
    endtask

    initial begin
        int t0;
        int n;
        reset    = 1'b1;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset values
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_cpu_hold", 64'(cpu_hold), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);

        // Full-rate load of two known words with latency and throughput checks
        img_q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        clear_capture();
        pulse_start();
        chk("full_in_ready_hdr", 64'(in_ready), 64'd1);
        send_range(0, 1, 1'b0);
        t0 = cyc;
        send_range(2, 9, 1'b0);
        chk("full_data_cycles", 64'(cyc - t0), 64'd9);
        chk("full_last_we", 64'(mem_we), 64'd1);
        chk("full_last_addr", 64'(mem_addr), 64'd1);
        chk("full_last_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        chk("full_hold_in_write", 64'(cpu_hold), 64'd1);
        chk("full_done_early", 64'(done), 64'd0);
        @(posedge clk); #1;
        chk("full_done", 64'(done), 64'd1);
        chk("full_cpu_hold", 64'(cpu_hold), 64'd0);
        chk("full_we_after", 64'(mem_we), 64'd0);
        chk("full_ready_after", 64'(in_ready), 64'd0);
        chk("full_addr_held", 64'(mem_addr), 64'd1);
        check_writes("full");

        // Zero count: straight to DONE, no writes
        img_q = '{8'h00, 8'h00};
        clear_capture();
        pulse_start();
        chk("zero_done_cleared", 64'(done), 64'd0);
        send_range(0, 1, 1'b0);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_cpu_hold", 64'(cpu_hold), 64'd0);
        @(posedge clk); #1;
        chk("zero_writes", 64'(wa_q.size()), 64'd0);

        // Overflow: count Depth+1 -> ERROR, cleared by the next start
        img_q = '{8'h21, 8'h00};
        clear_capture();
        pulse_start();
        send_range(0, 1, 1'b0);
        chk("ovf_error", 64'(error), 64'd1);
        chk("ovf_cpu_hold", 64'(cpu_hold), 64'd1);
        chk("ovf_in_ready", 64'(in_ready), 64'd0);
        chk("ovf_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        chk("ovf_writes", 64'(wa_q.size()), 64'd0);
        pulse_start();
        chk("ovf_error_cleared", 64'(error), 64'd0);
        chk("ovf_restart_ready", 64'(in_ready), 64'd1);
        do_reset();

        // Backpressure: same image with random gaps in in_valid
        img_q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        clear_capture();
        pulse_start();
        send_range(0, 9, 1'b1);
        wait_done();
        chk("bp_done", 64'(done), 64'd1);
        check_writes("bp");

        // Reset after the third data byte abandons the load
        clear_capture();
        pulse_start();
        send_range(0, 4, 1'b0);
        do_reset();
        chk("mid_in_ready", 64'(in_ready), 64'd0);
        chk("mid_mem_we", 64'(mem_we), 64'd0);
        chk("mid_mem_addr", 64'(mem_addr), 64'd0);
        chk("mid_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("mid_cpu_hold", 64'(cpu_hold), 64'd1);
        chk("mid_done", 64'(done), 64'd0);
        chk("mid_error", 64'(error), 64'd0);
        in_data  = 8'h12;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("mid_no_writes", 64'(wa_q.size()), 64'd0);
        img_q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        pulse_start();
        send_range(0, 5, 1'b0);
        wait_done();
        chk("mid_reload_done", 64'(done), 64'd1);
        check_writes("mid_reload");

        // start during DATA is ignored; start in DONE reloads and drops done
        img_q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        clear_capture();
        pulse_start();
        send_range(0, 3, 1'b0);
        pulse_start();
        send_range(4, 9, 1'b0);
        wait_done();
        chk("rs_done", 64'(done), 64'd1);
        chk("rs_error", 64'(error), 64'd0);
        check_writes("rs");
        pulse_start();
        chk("rs_done_drops", 64'(done), 64'd0);
        chk("rs_hold_back", 64'(cpu_hold), 64'd1);
        chk("rs_ready", 64'(in_ready), 64'd1);
        do_reset();

        // Randomised images, including the count == Depth boundary
        for (int r = 0; r < 6; r++) begin
            n = (r == 0) ? D : int'($urandom_range(1, D));
            build_image(n);
            clear_capture();
            pulse_start();
            send_range(0, img_q.size() - 1, 1'($urandom_range(0, 1)));
            wait_done();
            chk("rnd_done", 64'(done), 64'd1);
            chk("rnd_cpu_hold", 64'(cpu_hold), 64'd0);
            check_writes("rnd");
        end

        chk("ready_during_write", 64'(busy_writes), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the processor's instruction memory. It accepts a byte stream over a valid/ready interface, parses a 16-bit little-endian word-count header, packs the following bytes into `Width`-bit little-endian words and issues one write per word at incrementing addresses. It holds the core in reset via `cpu_hold` until the image is fully written, so it sits between the host/debug byte link and the write port of the single-port instruction memory.

## Interface
- `Width`, 32, instruction word width in bits; must be a multiple of 8, max 64
- `Depth`, 32, instruction memory depth in words
- `AddrWidth`, `$clog2(Depth)`, localparam, memory address width
- `BytesPerWord`, `Width/8`, localparam
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `start`  in  1  single-cycle pulse that begins a load
- `in_data`  in  8  stream byte
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  loader accepts a byte this cycle
- `mem_we`  out  1  instruction memory write strobe
- `mem_addr`  out  AddrWidth  write word address
- `mem_wdata`  out  Width  write word
- `cpu_hold`  out  1  keep the core in reset
- `done`  out  1  image written successfully (level)
- `error`  out  1  header count exceeded `Depth` (level)

## Operation
- States: IDLE, HDR_LO, HDR_HI, DATA, WRITE, DONE, ERROR.
- A byte transfers on a rising edge with `in_valid && in_ready`. `in_ready` = 1 only in HDR_LO, HDR_HI and DATA.
- IDLE: `start` moves to HDR_LO.
- HDR_LO: the transferred byte goes to count[7:0], then HDR_HI.
- HDR_HI: the transferred byte goes to count[15:8].
  - If count == 0, go to DONE.
  - If count > Depth, go to ERROR.
  - Otherwise clear the word index and byte index, then go to DATA.
- DATA: each transferred byte is placed at bits [8*k+7:8*k], where k = byte index (first byte is LSB). After byte `BytesPerWord-1`, go to WRITE.
- WRITE: exactly one cycle.
  - `mem_we`=1, `mem_addr` = word index, `mem_wdata` = the packed word.
  - If word index == count-1, go to DONE. Otherwise increment the word index, clear the byte index, return to DATA.
- DONE: `done`=1, `cpu_hold`=0.
- ERROR: `error`=1, `cpu_hold`=1.
- `start` is honoured only in IDLE, DONE and ERROR; on it the loader goes to HDR_LO and clears `done`/`error`. `start` is ignored in HDR_LO, HDR_HI, DATA and WRITE.
- `cpu_hold` = 1 in every state except DONE.
- Width rules:
  - Count is compared at 16 bits against `Depth`.
  - The word index is AddrWidth bits and never wraps, because count ≤ Depth.
  - The byte index is `$clog2(BytesPerWord)` bits, min 1.

## Timing
- Reset values: state IDLE, `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=1, `done`=0, `error`=0. Count and index registers are also cleared.
- Reset has priority over everything. Reset mid-load abandons the load with no further writes. Memory words already written stay written.
- `mem_addr`/`mem_wdata` are registered and hold their last value outside WRITE. `mem_we` is 1 only in WRITE.
- Latency:
  - The last byte of a word is accepted at edge N; `mem_we`=1 during cycle N+1.
  - For the last word, `done`=1 and `cpu_hold`=0 from cycle N+2.
- Throughput: `BytesPerWord`+1 cycles per word when the stream is full rate; gaps in `in_valid` simply stall.
- Header to DONE/ERROR: the state is visible the cycle after the HDR_HI byte is accepted.

## Structure
- Package `imem_loader_pkg`:
  - `imem_loader_state_t` enum
  - `HdrBytes` = 2
  - `MaxCountWidth` = 16
- Sub-module `byte_packer`:
  - Parameter `Width`.
  - Ports: `clk`, `reset`, `clear`, `byte_in`, `byte_en` → `word`, `last`.
  - Holds the byte index and the assembly register.

## Test plan
- Full load: Width=32, Depth=32, stream 02 00 | 78 56 34 12 | EF BE AD DE at full rate.
  - Writes addr0=0x12345678, addr1=0xDEADBEEF, one `mem_we` cycle each.
  - `done`=1 and `cpu_hold`=0 two cycles after the last byte.
- Zero count: stream 00 00 → DONE with no `mem_we` pulse.
- Overflow: stream 21 00 (count 33 > 32) → ERROR.
  - `error`=1, `cpu_hold`=1, `in_ready`=0, no writes.
  - A subsequent `start` clears `error`.
- Backpressure: same image as the full load, with `in_valid` toggled 1-0-1 randomly. The identical writes and data occur. `in_ready` is 0 during each WRITE cycle, and a byte offered then is taken the next cycle.
- Reset mid-load: assert `reset` for 1 cycle after the third data byte.
  - All outputs return to reset values; no `mem_we` follows.
  - A new `start` plus 01 00 AA BB CC DD writes addr0=0xDDCCBBAA.
- Restart: `start` asserted during DATA is ignored. `start` asserted in DONE reloads, and `done` drops the next cycle.
